// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator timebase logic.
// div_of converts a clock/output frequency pair into a half-period divisor.
package calc_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 32'd1;

  function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned out_hz);
    return clk_hz / out_hz / 32'd2 - 32'd1;
  endfunction

endpackage

// File: rtl/tick_ctrl.sv
// Run/stop controller for the timebase divider: divided square wave plus tick enable,
// with a valid/ready divisor update applied only at half-period boundaries.
module tick_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned DEF_HZ  = 1000,
  parameter int unsigned CW      = 32,
  parameter int unsigned MIN_DIV = calc_pkg::MIN_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_div,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          clk_out,
  output logic          tick,
  output logic          busy
);

  localparam logic [CW-1:0] DEF_DIV   = CW'(div_of(CLK_HZ, DEF_HZ));
  localparam logic [CW-1:0] MIN_DIV_W = CW'(MIN_DIV);
  localparam logic [CW-1:0] ONE_W     = CW'(1'b1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;

  logic          accept_s;
  logic          div_ok_s;
  logic          take_s;
  logic          wrap_s;

  assign accept_s = cfg_valid && (state_q != PEND);
  assign div_ok_s = (cfg_div >= MIN_DIV_W);
  assign take_s   = accept_s && div_ok_s;
  // counter never exceeds div_q, so >= is the same as == but stays safe after corruption
  assign wrap_s   = (cnt_q >= div_q);

  // Next-state, counter and divisor update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    err_d   = accept_s && !div_ok_s;

    case (state_q)
      RUN: begin
        if (stop) begin
          state_d = STOP;
          cnt_d   = '0;
          clk_d   = 1'b0;
          if (take_s) begin
            div_d = cfg_div;
          end else begin
            div_d = div_q;
          end
        end else begin
          if (wrap_s) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
          end else begin
            cnt_d  = cnt_q + ONE_W;
          end
          if (take_s) begin
            pend_d  = cfg_div;
            state_d = PEND;
          end else begin
            state_d = RUN;
          end
        end
      end

      PEND: begin
        if (stop) begin
          state_d = STOP;
          cnt_d   = '0;
          clk_d   = 1'b0;
          div_d   = pend_q;
        end else if (wrap_s) begin
          cnt_d   = '0;
          clk_d   = ~clk_q;
          tick_d  = ~clk_q;
          div_d   = pend_q;
          state_d = RUN;
        end else begin
          cnt_d   = cnt_q + ONE_W;
        end
      end

      STOP: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (take_s) begin
          div_d = cfg_div;
        end else begin
          div_d = div_q;
        end
        if (start && !stop) begin
          state_d = RUN;
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      div_q   <= DEF_DIV;
      pend_q  <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q == PEND);
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_tick_ctrl.sv
// Self-checking bench for tick_ctrl at CLK_HZ=1000, DEF_HZ=100 (default divisor 4).
// Expected output words are {clk_out, tick, cfg_ready, cfg_err, busy}.
module tb_tick_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_div = 32'd0;
  logic        cfg_ready, cfg_err, clk_out, tick, busy;
  logic [4:0]  obs;

  tick_ctrl #(
    .CLK_HZ (1000),
    .DEF_HZ (100),
    .CW     (32),
    .MIN_DIV(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign obs = {clk_out, tick, cfg_ready, cfg_err, busy};

  typedef struct packed {
    logic        st;
    logic        sp;
    logic        vld;
    logic [31:0] div;
    logic [7:0]  n;
    logic [4:0]  exp;
  } vec_t;

  vec_t       vecs [0:18];
  logic [4:0] sb_q [$];
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got clk/tick/rdy/err/busy=%b want %b at %0t", name, got, want, $time);
  endtask

  // called at a negedge, returns at the following negedge
  task automatic step(input logic st, input logic sp, input logic vld, input logic [31:0] d,
                      input logic [4:0] exp, input string name);
    logic [4:0] want;
    start     = st;
    stop      = sp;
    cfg_valid = vld;
    cfg_div   = d;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    check(name, obs, want);
    @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      for (int k = 0; k < int'(vecs[i].n); k++)
        step(vecs[i].st, vecs[i].sp, vecs[i].vld, vecs[i].div, vecs[i].exp,
             $sformatf("vec%0d.%0d", i, k));
  endtask

  task automatic idle(input int n, input logic [4:0] exp, input string name);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'd0, exp, $sformatf("%s.%0d", name, k));
  endtask

  initial begin
    // free run at divisor 4, then retune to 2 mid half-period, then a rejected divisor 0
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd4, 5'b00100};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd1, 5'b11100};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd4, 5'b10100};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd5, 5'b00100};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd1, 5'b11100};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd4, 5'b10100};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd2, 5'b00100};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd2, 8'd1, 5'b00001};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd2, 5'b00001};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd1, 5'b11100};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd2, 5'b10100};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd3, 5'b00100};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd1, 5'b11100};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd2, 5'b10100};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd3, 5'b00100};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'd0, 8'd1, 5'b11110};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd2, 5'b10100};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd3, 5'b00100};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'd0, 8'd1, 5'b11100};

    repeat (3) @(negedge clk);
    check("reset_values", obs, 5'b00100);
    rst_n = 1'b1;
    run_rows(0, 18);

    // divisor 7 pending, then stop commits it; start/stop together and idle stay stopped
    step(1'b0, 1'b0, 1'b1, 32'd7, 5'b10001, "pend7");
    step(1'b0, 1'b1, 1'b0, 32'd0, 5'b00100, "stop_in_pend");
    idle(6, 5'b00100, "stopped");
    step(1'b1, 1'b1, 1'b0, 32'd0, 5'b00100, "start_stop_same");
    idle(3, 5'b00100, "still_stopped");
    step(1'b1, 1'b0, 1'b0, 32'd0, 5'b00100, "start");
    idle(7, 5'b00100, "first_half_div7");
    step(1'b0, 1'b0, 1'b0, 32'd0, 5'b11100, "first_tick_div7");
    idle(7, 5'b10100, "high_half_div7");
    step(1'b0, 1'b0, 1'b0, 32'd0, 5'b00100, "fall_div7");

    // stop with an accepted divisor in RUN goes straight to STOP with divisor 5
    step(1'b0, 1'b1, 1'b1, 32'd5, 5'b00100, "stop_and_cfg");
    step(1'b1, 1'b0, 1'b0, 32'd0, 5'b00100, "restart");
    idle(5, 5'b00100, "low_div5");
    step(1'b0, 1'b0, 1'b0, 32'd0, 5'b11100, "tick_div5");
    idle(5, 5'b10100, "high_div5");
    step(1'b0, 1'b0, 1'b0, 32'd0, 5'b00100, "fall_div5");

    // reset while a divisor is pending discards it and restores the default period
    step(1'b0, 1'b0, 1'b1, 32'd3, 5'b00001, "pend3");
    step(1'b0, 1'b0, 1'b0, 32'd0, 5'b00001, "pend3_hold");
    rst_n = 1'b0;
    #1;
    check("async_reset", obs, 5'b00100);
    @(negedge clk);
    rst_n = 1'b1;
    run_rows(0, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
